cpu_clock_ctrl: RTL and testbench

Board-test clock controller for the single-cycle MIPS core. It generates a one-cycle clock-enable `cpu_ce` that advances the CPU. The enable comes from a divided rate tick and runs in one of three modes: free-run, single-step or N-cycle burst. Push buttons and a run switch on the board select the mode. It also drives a slow square wave for an LED and, optionally, counts executed CPU cycles.

---
 rtl/cpu_clock_ctrl.sv | 101 ++++++++++
 tb/tb_cpu_clock_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: rate-divided CPU clock-enable with free-run, single-step and burst modes.
// Define CLKCTRL_CYCLE_COUNT_EN to build the cpu_ce pulse counter on cycle_cnt.
module cpu_clock_ctrl #(
  parameter int DIV_N     = 24,
  parameter int DIV_M     = 5,
  parameter int DB_N      = 20,
  parameter int DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        burst_btn,
  input  logic [7:0]  burst_len,
  output logic        cpu_ce,
  output logic        slow_clk,
  output logic        busy,
  output logic [1:0]  state,
  output logic [15:0] cycle_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, STEP, BURST} st_t;
  st_t st;
  logic [2:0] s1, s2, db;
  logic [1:0] db_q, press;
  logic [DB_N-1:0] cnt [3];
  logic [DIV_N-1:0] r;
  logic [7:0] rem;
  logic tick;
  // bit 0 = run switch, bit 1 = step button, bit 2 = burst button
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {burst_btn, step_btn, run_sw};
      s2 <= s1;
    end
  // level flips once DB_CYCLES consecutive samples disagree with it
  always_ff @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (!rst_n) begin
        cnt[i] <= '0;
        db[i]  <= 1'b0;
      end else if (s2[i] == db[i]) cnt[i] <= '0;
      else if (cnt[i] == DB_N'(DB_CYCLES - 1)) begin
        db[i]  <= s2[i];
        cnt[i] <= '0;
      end else cnt[i] <= cnt[i] + 1'b1;
  always_ff @(posedge clk) db_q <= rst_n ? db[2:1] : 2'b00;
  assign press = db[2:1] & ~db_q;
  assign tick  = r == DIV_N'(DIV_M - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      r        <= '0;
      slow_clk <= 1'b0;
    end else begin
      r        <= tick ? '0 : r + 1'b1;
      slow_clk <= slow_clk ^ tick;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      st     <= IDLE;
      rem    <= '0;
      cpu_ce <= 1'b0;
    end else begin
      cpu_ce <= 1'b0;
      case (st)
        IDLE:
          if (db[0]) st <= RUN;
          else if (press[0]) st <= STEP;
          else if (press[1]) begin
            st  <= BURST;
            rem <= burst_len;
          end
        RUN: begin
          cpu_ce <= tick;
          if (!db[0]) st <= IDLE;
        end
        STEP:
          if (tick) begin
            cpu_ce <= 1'b1;
            st     <= IDLE;
          end
        default:
          if (rem == 8'd0) st <= IDLE;
          else if (tick) begin
            cpu_ce <= 1'b1;
            rem    <= rem - 1'b1;
          end
      endcase
    end
  assign state = st;
  assign busy  = st != IDLE;
`ifdef CLKCTRL_CYCLE_COUNT_EN
  always_ff @(posedge clk)
    if (!rst_n) cycle_cnt <= '0;
    else cycle_cnt <= cycle_cnt + {15'd0, cpu_ce};
`else
  assign cycle_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: vector table, corner sequences and random stimulus against a cycle model.
module tb_cpu_clock_ctrl;
  localparam int M  = 5;
  localparam int DB = 4;
  logic clk = 1'b0, rst_n = 1'b0, run_sw = 1'b0, step_btn = 1'b0, burst_btn = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic cpu_ce, slow_clk, busy;
  logic [1:0] state;
  logic [15:0] cycle_cnt;
  int n_cmp = 0, n_bad = 0, seen = 0;

  cpu_clock_ctrl #(.DIV_N(24), .DIV_M(M), .DB_N(20), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn), .burst_btn(burst_btn),
    .burst_len(burst_len), .cpu_ce(cpu_ce), .slow_clk(slow_clk), .busy(busy),
    .state(state), .cycle_cnt(cycle_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: debounce as "last DB synchronized samples all disagree",
  // tick from elapsed cycles modulo M, modes as plain integers
  int m_t, m_mode, m_rem, m_ticks, m_pulses;
  bit m_ce, armed;
  bit m_db[3], m_dbq[3];
  bit m_hist[3][DB+1];
  always @(posedge clk) begin
    bit raw[3];
    bit tk, sp, bp, nce, all_diff;
    raw[0] = run_sw; raw[1] = step_btn; raw[2] = burst_btn;
    if (!rst_n) begin
      m_t = 0; m_mode = 0; m_rem = 0; m_ticks = 0; m_pulses = 0; m_ce = 0;
      for (int i = 0; i < 3; i++) begin
        m_db[i] = 0; m_dbq[i] = 0;
        for (int k = 0; k <= DB; k++) m_hist[i][k] = 0;
      end
    end else begin
      tk = (m_t % M) == M - 1;
      sp = m_db[1] && !m_dbq[1];
      bp = m_db[2] && !m_dbq[2];
      nce = 0;
      if (m_ce) m_pulses++;
      case (m_mode)
        0: if (m_db[0]) m_mode = 1;
           else if (sp) m_mode = 2;
           else if (bp) begin m_mode = 3; m_rem = burst_len; end
        1: begin nce = tk; if (!m_db[0]) m_mode = 0; end
        2: if (tk) begin nce = 1; m_mode = 0; end
        default: if (m_rem == 0) m_mode = 0;
                 else if (tk) begin nce = 1; m_rem--; end
      endcase
      if (tk) m_ticks++;
      m_ce = nce;
      for (int i = 0; i < 3; i++) begin
        m_dbq[i] = m_db[i];
        all_diff = 1;
        for (int k = 1; k <= DB; k++) if (m_hist[i][k] == m_db[i]) all_diff = 0;
        if (all_diff) m_db[i] = !m_db[i];
        for (int k = DB; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = raw[i];
      end
      m_t++;
    end
    armed = 1;
  end

  always @(negedge clk)
    if (armed) begin
      chk("ce", cpu_ce, m_ce);
      chk("state", state, m_mode);
      chk("busy", busy, m_mode != 0);
      chk("slow_clk", slow_clk, m_ticks & 1);
`ifdef CLKCTRL_CYCLE_COUNT_EN
      chk("cycle_cnt", cycle_cnt, m_pulses & 16'hffff);
`else
      chk("cycle_cnt", cycle_cnt, 0);
`endif
    end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      seen += int'(cpu_ce);
    end
  endtask

  typedef struct {
    logic run; logic step; logic burst; logic [7:0] len;
    int hold; int idle; int pulses; logic [1:0] fin;
  } vec_t;
  vec_t vt[6];

  initial begin
    int k, last, got;
    vt[0] = '{1'b0, 1'b1, 1'b0, 8'd0,   10, 20,   1,   2'd0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 8'd3,   10, 30,   3,   2'd0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 8'd0,   10, 10,   0,   2'd0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 8'd5,   10, 20,   1,   2'd0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 8'd7,   10, 50,   7,   2'd0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 8'd255, 10, 1300, 255, 2'd0};
    run_sw = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out", {cpu_ce, slow_clk, busy, state, cycle_cnt}, 0);
    end
    rst_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (state !== 2'd1 && k < 20);
    chk("run_latency", k, 7);
    last = -1; got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (cpu_ce) begin
        if (last >= 0) chk("run_gap", c - last, M);
        last = c; got++;
      end
    end
    chk("run_pulses", got, 4);
    run_sw = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (state !== 2'd0 && k < 20);
    chk("off_idle", state, 0);
    seen = 0; cyc(20);
    chk("off_pulses", seen, 0);
    chk("off_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      run_sw = vt[i].run; step_btn = vt[i].step; burst_btn = vt[i].burst; burst_len = vt[i].len;
      seen = 0;
      cyc(vt[i].hold);
      step_btn = 1'b0; burst_btn = 1'b0;
      cyc(vt[i].idle);
      chk($sformatf("vec%0d_pulses", i), seen, vt[i].pulses);
      chk($sformatf("vec%0d_state", i), state, vt[i].fin);
    end

    step_btn = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (state !== 2'd2 && k < 20);
    chk("step_enter", state, 2);
    k = 0;
    do begin @(negedge clk); k++; end while (!cpu_ce && k < 10);
    chk("step_latency_in_range", k >= 1 && k <= M, 1);
    step_btn = 1'b0; cyc(15);
    chk("step_idle", state, 0);

    burst_len = 8'd3; burst_btn = 1'b1; seen = 0;
    cyc(10);
    burst_btn = 1'b0; step_btn = 1'b1;
    cyc(10);
    step_btn = 1'b0;
    cyc(30);
    chk("burst_step_ignored", seen, 3);
    chk("burst_step_idle", state, 0);

    burst_len = 8'd0; burst_btn = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (state !== 2'd3 && k < 20);
    chk("zero_enter", state, 3);
    @(negedge clk);
    chk("zero_exit", state, 0);
    chk("zero_ce", cpu_ce, 0);
    burst_btn = 1'b0; cyc(10);

    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step_btn = (i % 2 == 0);
      cyc(2);
    end
    step_btn = 1'b0; cyc(15);
    chk("bounce_pulses", seen, 0);
    chk("bounce_state", state, 0);

    burst_len = 8'd10; burst_btn = 1'b1; seen = 0;
    cyc(10);
    burst_btn = 1'b0;
    for (int c = 0; c < 60 && seen < 4; c++) cyc(1);
    chk("mid_pulses", seen, 4);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_ce", cpu_ce, 0);
    chk("mid_rst_cnt", cycle_cnt, 0);
    cyc(2);
    rst_n = 1'b1; seen = 0;
    cyc(40);
    chk("mid_after_pulses", seen, 0);
    chk("mid_after_state", state, 0);

    for (int i = 0; i < 250; i++) begin
      run_sw    = ($urandom_range(0, 7) == 0);
      step_btn  = 1'($urandom_range(0, 1));
      burst_btn = 1'($urandom_range(0, 1));
      burst_len = 8'($urandom_range(0, 6));
      cyc($urandom_range(1, 12));
    end
    run_sw = 1'b0; step_btn = 1'b0; burst_btn = 1'b0;
    cyc(100);
    chk("final_idle", state, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
